// File: rtl/eq_compare_sequencer.sv
// Byte-serial equality compare controller: round-robin arbitration between two
// requesters, LSB-first byte sequencing through a shared 8-bit slice, early exit on mismatch.
module eq_compare_sequencer #(
    parameter int WORD_BYTES = 4,
    parameter int CW         = $clog2(WORD_BYTES + 1)
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    req0_valid,
    output logic                    req0_ready,
    input  logic [8*WORD_BYTES-1:0] req0_a,
    input  logic [8*WORD_BYTES-1:0] req0_b,
    input  logic                    req1_valid,
    output logic                    req1_ready,
    input  logic [8*WORD_BYTES-1:0] req1_a,
    input  logic [8*WORD_BYTES-1:0] req1_b,
    output logic [7:0]              cmp_a,
    output logic [7:0]              cmp_b,
    input  logic                    cmp_eq,
    output logic                    resp_valid,
    input  logic                    resp_ready,
    output logic                    resp_id,
    output logic                    resp_eq,
    output logic [CW-1:0]           resp_bytes
);
    localparam int W  = 8 * WORD_BYTES;
    localparam int IW = (WORD_BYTES > 1) ? $clog2(WORD_BYTES) : 1;

    typedef enum logic [1:0] {IDLE, CMP, DONE} state_t;

    state_t        state_q;
    logic          last_q;
    logic [W-1:0]  rem_a_q;
    logic [W-1:0]  rem_b_q;
    logic [IW-1:0] idx_q;
    logic [7:0]    cmp_a_q;
    logic [7:0]    cmp_b_q;
    logic          resp_valid_q;
    logic          resp_id_q;
    logic          resp_eq_q;
    logic [CW-1:0] resp_bytes_q;

    logic          grant0_d;
    logic          grant1_d;
    logic          accept_d;
    logic          last_byte_d;
    logic [W-1:0]  sel_a_d;
    logic [W-1:0]  sel_b_d;

    // last_q = 1 means req1 was granted most recently, so req0 wins a tie.
    assign grant0_d    = req0_valid & (~req1_valid | last_q);
    assign grant1_d    = req1_valid & (~req0_valid | ~last_q);
    assign req0_ready  = (state_q == IDLE) & grant0_d;
    assign req1_ready  = (state_q == IDLE) & grant1_d;
    assign accept_d    = req0_ready | req1_ready;
    assign sel_a_d     = grant1_d ? req1_a : req0_a;
    assign sel_b_d     = grant1_d ? req1_b : req0_b;
    assign last_byte_d = (idx_q == IW'(WORD_BYTES - 1));

    assign cmp_a      = cmp_a_q;
    assign cmp_b      = cmp_b_q;
    assign resp_valid = resp_valid_q;
    assign resp_id    = resp_id_q;
    assign resp_eq    = resp_eq_q;
    assign resp_bytes = resp_bytes_q;

    // rem_*_q hold the bytes not yet presented; they shift down one byte per step.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            last_q       <= 1'b1;
            rem_a_q      <= '0;
            rem_b_q      <= '0;
            idx_q        <= '0;
            cmp_a_q      <= '0;
            cmp_b_q      <= '0;
            resp_valid_q <= 1'b0;
            resp_id_q    <= 1'b0;
            resp_eq_q    <= 1'b0;
            resp_bytes_q <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (accept_d) begin
                        rem_a_q   <= sel_a_d >> 8;
                        rem_b_q   <= sel_b_d >> 8;
                        cmp_a_q   <= sel_a_d[7:0];
                        cmp_b_q   <= sel_b_d[7:0];
                        idx_q     <= '0;
                        resp_id_q <= grant1_d;
                        last_q    <= grant1_d;
                        state_q   <= CMP;
                    end
                end
                CMP: begin
                    if (!cmp_eq || last_byte_d) begin
                        resp_valid_q <= 1'b1;
                        resp_eq_q    <= cmp_eq;
                        resp_bytes_q <= CW'(idx_q) + CW'(1);
                        cmp_a_q      <= '0;
                        cmp_b_q      <= '0;
                        state_q      <= DONE;
                    end else begin
                        idx_q   <= idx_q + 1'b1;
                        cmp_a_q <= rem_a_q[7:0];
                        cmp_b_q <= rem_b_q[7:0];
                        rem_a_q <= rem_a_q >> 8;
                        rem_b_q <= rem_b_q >> 8;
                    end
                end
                DONE: begin
                    if (resp_ready) begin
                        resp_valid_q <= 1'b0;
                        state_q      <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_eq_compare_sequencer.sv
// Scoreboard bench for eq_compare_sequencer: a WORD_BYTES=4 instance under a
// negedge monitor with an arbitration/compare model, plus a WORD_BYTES=1 instance.
module tb_eq_compare_sequencer;
    localparam int WB = 4;
    localparam int W  = 8 * WB;
    localparam int CW = $clog2(WB + 1);

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          req0_valid = 1'b0, req1_valid = 1'b0;
    logic [W-1:0]  req0_a = '0, req0_b = '0, req1_a = '0, req1_b = '0;
    logic          req0_ready, req1_ready;
    logic [7:0]    cmp_a, cmp_b;
    logic          cmp_eq;
    logic          resp_valid, resp_id, resp_eq;
    logic          resp_ready = 1'b1;
    logic [CW-1:0] resp_bytes;

    logic          w1_valid = 1'b0;
    logic [7:0]    w1_a = '0, w1_b = '0;
    logic          w1_ready0, w1_ready1;
    logic [7:0]    w1_cmp_a, w1_cmp_b;
    logic          w1_cmp_eq;
    logic          w1_resp_valid, w1_resp_id, w1_resp_eq;
    logic [0:0]    w1_resp_bytes;

    always #5 clk = ~clk;
    assign cmp_eq    = (cmp_a == cmp_b);
    assign w1_cmp_eq = (w1_cmp_a == w1_cmp_b);

    eq_compare_sequencer #(.WORD_BYTES(WB)) dut (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a), .req0_b(req0_b),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a), .req1_b(req1_b),
        .cmp_a(cmp_a), .cmp_b(cmp_b), .cmp_eq(cmp_eq),
        .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_id(resp_id),
        .resp_eq(resp_eq), .resp_bytes(resp_bytes)
    );

    eq_compare_sequencer #(.WORD_BYTES(1)) dut_w1 (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(w1_valid), .req0_ready(w1_ready0), .req0_a(w1_a), .req0_b(w1_b),
        .req1_valid(1'b0), .req1_ready(w1_ready1), .req1_a(8'h00), .req1_b(8'h00),
        .cmp_a(w1_cmp_a), .cmp_b(w1_cmp_b), .cmp_eq(w1_cmp_eq),
        .resp_valid(w1_resp_valid), .resp_ready(1'b1), .resp_id(w1_resp_id),
        .resp_eq(w1_resp_eq), .resp_bytes(w1_resp_bytes)
    );

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at cycle %0d", tag, got, exp, cyc);
        end
    endtask

    function automatic void model_cmp(input logic [W-1:0] a, input logic [W-1:0] b,
                                      output int k, output bit eq);
        k  = WB;
        eq = 1'b1;
        for (int i = WB - 1; i >= 0; i--)
            if (a[8*i +: 8] != b[8*i +: 8]) begin
                k  = i + 1;
                eq = 1'b0;
            end
    endfunction

    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic id;
        logic eq;
        int   k;
        int   due;
    } exp_t;
    exp_t sb[$];

    bit           busy_m = 1'b0, last_m = 1'b1, resp_seen = 1'b0;
    bit           exp_r0, exp_r1, m_eq;
    int           m_k, e0_m = 0, k_m = 0;
    logic [W-1:0] fa_m = '0, fb_m = '0;
    logic [7:0]   exp_ca, exp_cb;

    // Inputs only change just after a rising edge, so what is seen here is what the next edge acts on.
    always @(negedge clk) begin
        if (!rst_n) begin
            sb.delete();
            busy_m    = 1'b0;
            last_m    = 1'b1;
            resp_seen = 1'b0;
        end else begin
            exp_r0 = !busy_m && req0_valid && (!req1_valid || last_m);
            exp_r1 = !busy_m && req1_valid && (!req0_valid || !last_m);
            check("req0_ready", req0_ready, exp_r0);
            check("req1_ready", req1_ready, exp_r1);

            exp_ca = 8'h00;
            exp_cb = 8'h00;
            if (busy_m && cyc >= e0_m && cyc < e0_m + k_m) begin
                exp_ca = 8'(fa_m >> (8 * (cyc - e0_m)));
                exp_cb = 8'(fb_m >> (8 * (cyc - e0_m)));
            end
            check("cmp_a", cmp_a, exp_ca);
            check("cmp_b", cmp_b, exp_cb);

            if (sb.size() > 0 && !resp_seen && !resp_valid && cyc >= sb[0].due)
                check("resp_late", resp_valid, 1);

            if (resp_valid) begin
                if (sb.size() == 0) begin
                    check("resp_unexpected", resp_valid, 0);
                end else begin
                    if (!resp_seen) check("resp_latency", cyc, sb[0].due);
                    check("resp_id", resp_id, sb[0].id);
                    check("resp_eq", resp_eq, sb[0].eq);
                    check("resp_bytes", resp_bytes, sb[0].k);
                    if (resp_ready) begin
                        $display("resp id=%0d eq=%0d bytes=%0d cycle=%0d",
                                 resp_id, resp_eq, resp_bytes, cyc);
                        void'(sb.pop_front());
                        resp_seen = 1'b0;
                        busy_m    = 1'b0;
                    end else begin
                        resp_seen = 1'b1;
                    end
                end
            end

            if (exp_r0 || exp_r1) begin
                fa_m = exp_r1 ? req1_a : req0_a;
                fb_m = exp_r1 ? req1_b : req0_b;
                model_cmp(fa_m, fb_m, m_k, m_eq);
                e0_m   = cyc + 1;
                k_m    = m_k;
                busy_m = 1'b1;
                last_m = exp_r1;
                sb.push_back('{id: exp_r1, eq: m_eq, k: m_k, due: e0_m + m_k});
            end
        end
    end

    task automatic send(input bit id, input logic [W-1:0] a, input logic [W-1:0] b);
        bit got = 1'b0;
        if (id) begin req1_a = a; req1_b = b; req1_valid = 1'b1; end
        else    begin req0_a = a; req0_b = b; req0_valid = 1'b1; end
        for (int i = 0; i < 100 && !got; i++) begin
            @(negedge clk);
            got = id ? req1_ready : req0_ready;
        end
        if (!got) check("send_timeout", 0, 1);
        @(posedge clk); #1;
        if (id) req1_valid = 1'b0; else req0_valid = 1'b0;
    endtask

    task automatic wait_idle();
        bit ok = 1'b0;
        for (int i = 0; i < 100 && !ok; i++) begin
            @(posedge clk); #1;
            ok = (sb.size() == 0) && !resp_valid;
        end
        if (!ok) check("idle_timeout", 0, 1);
    endtask

    task automatic check_outputs_zero(input string when);
        check({when, "_resp_valid"}, resp_valid, 0);
        check({when, "_resp_eq"}, resp_eq, 0);
        check({when, "_resp_id"}, resp_id, 0);
        check({when, "_resp_bytes"}, resp_bytes, 0);
        check({when, "_cmp_a"}, cmp_a, 0);
        check({when, "_cmp_b"}, cmp_b, 0);
        check({when, "_req0_ready"}, req0_ready, 0);
        check({when, "_req1_ready"}, req1_ready, 0);
    endtask

    task automatic w1_run(input logic [7:0] a, input logic [7:0] b);
        bit got = 1'b0;
        w1_a = a; w1_b = b; w1_valid = 1'b1;
        for (int i = 0; i < 20 && !got; i++) begin
            @(negedge clk);
            got = w1_ready0;
        end
        if (!got) check("w1_timeout", 0, 1);
        @(posedge clk); #1;
        w1_valid = 1'b0;
        @(negedge clk);
        check("w1_cmp_a", w1_cmp_a, a);
        check("w1_early_valid", w1_resp_valid, 0);
        @(negedge clk);
        check("w1_resp_valid", w1_resp_valid, 1);
        check("w1_resp_id", w1_resp_id, 0);
        check("w1_resp_eq", w1_resp_eq, (a == b) ? 1 : 0);
        check("w1_resp_bytes", w1_resp_bytes, 1);
        $display("w1 resp a=%02h b=%02h eq=%0d bytes=%0d", a, b, w1_resp_eq, w1_resp_bytes);
        @(posedge clk); #1;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got no end expected end");
        $fatal(1);
    end

    initial begin
        int   order[$];
        int   n, hs;
        bit   a0, a1, got;
        int   exp_order[5] = '{0, 1, 0, 1, 0};

        #3;
        check_outputs_zero("reset");
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk); #1;

        send(0, 32'hDEADBEEF, 32'hDEADBEEF);
        wait_idle();
        send(1, 32'h11223344, 32'h11225544);
        wait_idle();

        req0_a = 32'h0A0B0C0D; req0_b = req0_a;
        req1_a = 32'h01020304; req1_b = req1_a;
        req0_valid = 1'b1; req1_valid = 1'b1;
        n = 0;
        for (int i = 0; i < 200 && (req0_valid || req1_valid); i++) begin
            @(negedge clk);
            a0 = req0_ready;
            a1 = req1_ready;
            if (a0 && a1) check("both_ready", 1, 0);
            @(posedge clk); #1;
            if (a0) begin
                order.push_back(0); n++;
                req0_a = req0_a + 32'h01010101; req0_b = req0_a;
                if (n >= 4) req0_valid = 1'b0;
            end
            if (a1) begin
                order.push_back(1); n++;
                req1_a = req1_a + 32'h10101010; req1_b = req1_a;
                if (n >= 4) req1_valid = 1'b0;
            end
        end
        check("grant_count", order.size(), 5);
        for (int i = 0; i < 5 && i < order.size(); i++)
            check($sformatf("grant%0d", i), order[i], exp_order[i]);
        wait_idle();

        resp_ready = 1'b0;
        send(0, 32'h01020304, 32'h01020305);
        req1_a = 32'h55667788; req1_b = 32'h55667788; req1_valid = 1'b1;
        got = 1'b0;
        for (int i = 0; i < 20 && !got; i++) begin
            @(negedge clk);
            got = resp_valid;
        end
        if (!got) check("bp_resp_timeout", 0, 1);
        repeat (3) @(posedge clk);
        #1 resp_ready = 1'b1;
        @(negedge clk);
        check("bp_hs_valid", resp_valid, 1);
        hs = cyc;
        got = 1'b0;
        for (int i = 0; i < 20 && !got; i++) begin
            @(negedge clk);
            got = req1_ready;
        end
        if (!got) check("bp_grant_timeout", 0, 1);
        check("bp_grant_delay", cyc - hs, 1);
        @(posedge clk); #1 req1_valid = 1'b0;
        wait_idle();

        send(0, 32'hCAFEF00D, 32'hCAFEF00D);
        @(posedge clk); #1;
        check("rst_pre_cmp_a", cmp_a, 8'hF0);
        #1 rst_n = 1'b0;
        #1;
        check_outputs_zero("midrst");
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (6) @(negedge clk);
        check("post_rst_no_resp", resp_valid, 0);
        @(posedge clk); #1;
        send(1, 32'hA5A5A5A5, 32'h25A5A5A5);
        wait_idle();

        w1_run(8'h5A, 8'h5B);
        w1_run(8'h5A, 8'h5A);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
